ddr_cmd_sequencer: RTL and testbench



---
 rtl/ddr_cmd_sequencer.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_ddr_cmd_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_cmd_sequencer.sv
// ddr_cmd_sequencer
// Command-side controller for the two-phase DFI command interface of the
// Spartan-6 DDR PHY. After reset it runs the DDR power-up and mode-register
// sequence. It then issues periodic auto-refresh and, between refreshes,
// forwards single host commands onto DFI phase 0. Phase 1 always carries NOP.
//
// Ports
//   sys_clk, sys_rst          : clock (rising edge) and async active-high reset
//   cmd_valid / cmd_ready     : host handshake; the accepted command appears
//                               on p0 one cycle after the cycle it was offered
//   cmd_ras_n/cas_n/we_n      : host command encoding (cs_n is implied low)
//   cmd_bank, cmd_address     : host bank / address
//   init_done                 : power-up sequence complete
//   refresh_active            : a refresh is pending or in progress
//   dfi_cke_p0/p1             : clock enable (both phases identical)
//   dfi_*_p0                  : phase-0 command, bank, address
//   dfi_*_p1                  : phase-1 command, bank, address (always NOP)
//
// T_RP, T_MRD and T_RFC are expected to be at least 2.
module ddr_cmd_sequencer #(
    parameter int                NUM_AD    = 13,
    parameter int                NUM_BA    = 2,
    parameter int                T_INIT    = 200,
    parameter int                T_RP      = 2,
    parameter int                T_MRD     = 2,
    parameter int                T_RFC     = 8,
    parameter int                T_REFI    = 780,
    parameter logic [NUM_AD-1:0] MR_VALUE  = NUM_AD'(13'h0022),
    parameter logic [NUM_AD-1:0] EMR_VALUE = NUM_AD'(13'h0000)
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_ras_n,
    input  logic              cmd_cas_n,
    input  logic              cmd_we_n,
    input  logic [NUM_BA-1:0] cmd_bank,
    input  logic [NUM_AD-1:0] cmd_address,
    output logic              init_done,
    output logic              refresh_active,
    output logic              dfi_cke_p0,
    output logic              dfi_cke_p1,
    output logic              dfi_cs_n_p0,
    output logic              dfi_ras_n_p0,
    output logic              dfi_cas_n_p0,
    output logic              dfi_we_n_p0,
    output logic [NUM_BA-1:0] dfi_bank_p0,
    output logic [NUM_AD-1:0] dfi_address_p0,
    output logic              dfi_cs_n_p1,
    output logic              dfi_ras_n_p1,
    output logic              dfi_cas_n_p1,
    output logic              dfi_we_n_p1,
    output logic [NUM_BA-1:0] dfi_bank_p1,
    output logic [NUM_AD-1:0] dfi_address_p1
);

    localparam int CMAX_A = (T_INIT > T_RFC) ? T_INIT : T_RFC;
    localparam int CMAX_B = (T_RP > T_MRD) ? T_RP : T_MRD;
    localparam int CMAX   = (CMAX_A > CMAX_B) ? CMAX_A : CMAX_B;
    localparam int CW     = $clog2(CMAX + 1);
    localparam int TW     = $clog2(T_REFI + 1);

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_LMR = 4'b0000;
    localparam logic [3:0] CMD_DES = 4'b1111;

    localparam logic [NUM_AD-1:0] A10_MASK = NUM_AD'(11'h400);
    localparam logic [NUM_AD-1:0] A8_MASK  = NUM_AD'(11'h100);

    typedef enum logic [3:0] {
        S_INIT_WAIT,
        S_INIT_PRE0,
        S_INIT_EMR,
        S_INIT_MR_DLL,
        S_INIT_PRE1,
        S_INIT_REF0,
        S_INIT_REF1,
        S_INIT_MR,
        S_INIT_FIN,
        S_IDLE,
        S_WAIT,
        S_REF_PRE,
        S_REF_REF,
        S_REF_FIN
    } state_t;

    state_t              state_q;
    state_t              ret_q;
    logic [CW-1:0]       cnt_q;
    logic [TW-1:0]       timer_q;
    logic                ref_pending_q;
    logic                init_done_q;
    logic                cmd_ready_q;
    logic                cke_q;
    logic [3:0]          p0_cmd_q;
    logic [NUM_BA-1:0]   p0_bank_q;
    logic [NUM_AD-1:0]   p0_addr_q;
    logic                p1_cs_n_q;

    logic                expire_s;
    logic                host_xfer_s;
    logic                issue_s;
    logic [3:0]          iss_cmd_s;
    logic [NUM_BA-1:0]   iss_bank_s;
    logic [NUM_AD-1:0]   iss_addr_s;
    logic [CW-1:0]       iss_wait_s;
    state_t              iss_after_s;

    assign expire_s    = init_done_q && (timer_q == TW'(T_REFI - 1));
    assign host_xfer_s = cmd_valid && cmd_ready_q;

    // Refresh interval timer and the pending flag it raises; an expiry while
    // a refresh is already pending simply leaves the flag set.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            timer_q       <= {TW{1'b0}};
            ref_pending_q <= 1'b0;
        end else begin
            if (!init_done_q || expire_s) begin
                timer_q <= {TW{1'b0}};
            end else begin
                timer_q <= timer_q + TW'(1);
            end
            if (expire_s) begin
                ref_pending_q <= 1'b1;
            end else if (state_q == S_REF_FIN) begin
                ref_pending_q <= 1'b0;
            end else begin
                ref_pending_q <= ref_pending_q;
            end
        end
    end

    // Command table for states that put a sequencer command on p0: what to
    // issue, how long the following gap is (loaded as gap-2 into the WAIT
    // counter) and where to resume afterwards.
    always_comb begin
        issue_s     = 1'b1;
        iss_cmd_s   = CMD_NOP;
        iss_bank_s  = {NUM_BA{1'b0}};
        iss_addr_s  = {NUM_AD{1'b0}};
        iss_wait_s  = CW'(T_RP - 2);
        iss_after_s = S_IDLE;
        case (state_q)
            S_INIT_PRE0: begin
                iss_cmd_s = CMD_PRE; iss_addr_s = A10_MASK;
                iss_wait_s = CW'(T_RP - 2); iss_after_s = S_INIT_EMR;
            end
            S_INIT_EMR: begin
                iss_cmd_s = CMD_LMR; iss_bank_s = NUM_BA'(1'b1); iss_addr_s = EMR_VALUE;
                iss_wait_s = CW'(T_MRD - 2); iss_after_s = S_INIT_MR_DLL;
            end
            S_INIT_MR_DLL: begin
                iss_cmd_s = CMD_LMR; iss_addr_s = MR_VALUE | A8_MASK;
                iss_wait_s = CW'(T_MRD - 2); iss_after_s = S_INIT_PRE1;
            end
            S_INIT_PRE1: begin
                iss_cmd_s = CMD_PRE; iss_addr_s = A10_MASK;
                iss_wait_s = CW'(T_RP - 2); iss_after_s = S_INIT_REF0;
            end
            S_INIT_REF0: begin
                iss_cmd_s = CMD_REF;
                iss_wait_s = CW'(T_RFC - 2); iss_after_s = S_INIT_REF1;
            end
            S_INIT_REF1: begin
                iss_cmd_s = CMD_REF;
                iss_wait_s = CW'(T_RFC - 2); iss_after_s = S_INIT_MR;
            end
            S_INIT_MR: begin
                iss_cmd_s = CMD_LMR; iss_addr_s = MR_VALUE & ~A8_MASK;
                iss_wait_s = CW'(T_MRD - 2); iss_after_s = S_INIT_FIN;
            end
            S_REF_PRE: begin
                iss_cmd_s = CMD_PRE; iss_addr_s = A10_MASK;
                iss_wait_s = CW'(T_RP - 2); iss_after_s = S_REF_REF;
            end
            S_REF_REF: begin
                iss_cmd_s = CMD_REF;
                iss_wait_s = CW'(T_RFC - 2); iss_after_s = S_REF_FIN;
            end
            default: begin
                issue_s = 1'b0;
            end
        endcase
    end

    // Main sequencer FSM with registered DFI outputs and handshake.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= S_INIT_WAIT;
            ret_q       <= S_INIT_WAIT;
            cnt_q       <= {CW{1'b0}};
            init_done_q <= 1'b0;
            cmd_ready_q <= 1'b0;
            cke_q       <= 1'b0;
            p0_cmd_q    <= CMD_DES;
            p0_bank_q   <= {NUM_BA{1'b0}};
            p0_addr_q   <= {NUM_AD{1'b0}};
            p1_cs_n_q   <= 1'b1;
        end else begin
            p0_cmd_q    <= CMD_NOP;
            p0_bank_q   <= {NUM_BA{1'b0}};
            p0_addr_q   <= {NUM_AD{1'b0}};
            p1_cs_n_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            if (issue_s) begin
                p0_cmd_q  <= iss_cmd_s;
                p0_bank_q <= iss_bank_s;
                p0_addr_q <= iss_addr_s;
                state_q   <= S_WAIT;
                cnt_q     <= iss_wait_s;
                ret_q     <= iss_after_s;
            end else begin
                case (state_q)
                    S_INIT_WAIT: begin
                        if (cnt_q == CW'(T_INIT - 1)) begin
                            cke_q   <= 1'b1;
                            cnt_q   <= {CW{1'b0}};
                            state_q <= S_INIT_PRE0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    S_WAIT: begin
                        if (cnt_q == {CW{1'b0}}) begin
                            state_q <= ret_q;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    S_INIT_FIN: begin
                        init_done_q <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                    S_IDLE: begin
                        // A host command accepted on the expiry edge still goes
                        // out; the pre-refresh guard counts from this edge.
                        if (host_xfer_s) begin
                            p0_cmd_q  <= {1'b0, cmd_ras_n, cmd_cas_n, cmd_we_n};
                            p0_bank_q <= cmd_bank;
                            p0_addr_q <= cmd_address;
                        end
                        if (expire_s || ref_pending_q) begin
                            state_q <= S_WAIT;
                            cnt_q   <= CW'(T_RP - 2);
                            ret_q   <= S_REF_PRE;
                        end else begin
                            cmd_ready_q <= 1'b1;
                        end
                    end
                    S_REF_FIN: begin
                        // A fresh expiry on the completion edge starts the next
                        // refresh guard straight away.
                        if (expire_s) begin
                            state_q <= S_WAIT;
                            cnt_q   <= CW'(T_RP - 2);
                            ret_q   <= S_REF_PRE;
                        end else begin
                            state_q     <= S_IDLE;
                            cmd_ready_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_INIT_WAIT;
                    end
                endcase
            end
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign init_done      = init_done_q;
    assign refresh_active = ref_pending_q;
    assign dfi_cke_p0     = cke_q;
    assign dfi_cke_p1     = cke_q;
    assign dfi_cs_n_p0    = p0_cmd_q[3];
    assign dfi_ras_n_p0   = p0_cmd_q[2];
    assign dfi_cas_n_p0   = p0_cmd_q[1];
    assign dfi_we_n_p0    = p0_cmd_q[0];
    assign dfi_bank_p0    = p0_bank_q;
    assign dfi_address_p0 = p0_addr_q;
    assign dfi_cs_n_p1    = p1_cs_n_q;
    assign dfi_ras_n_p1   = 1'b1;
    assign dfi_cas_n_p1   = 1'b1;
    assign dfi_we_n_p1    = 1'b1;
    assign dfi_bank_p1    = {NUM_BA{1'b0}};
    assign dfi_address_p1 = {NUM_AD{1'b0}};

endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// Testbench for ddr_cmd_sequencer. Instance 0 uses T_REFI=50 with a held
// host ACT stream and random host traffic; instance 1 uses T_REFI=6, shorter
// than a refresh sequence, so expiries land while a refresh is pending.
module tb_ddr_cmd_sequencer;

    localparam int TI      = 10;
    localparam int TRP     = 2;
    localparam int TMRD    = 2;
    localparam int TRFC    = 4;
    localparam int TREFI_A = 50;
    localparam int TREFI_B = 6;
    localparam logic [12:0] MRV  = 13'h0022;
    localparam logic [12:0] EMRV = 13'h0000;

    logic        sys_clk;
    logic        sys_rst;
    logic        valid   [2];
    logic        ras_i   [2];
    logic        cas_i   [2];
    logic        we_i    [2];
    logic [1:0]  bank_i  [2];
    logic [12:0] addr_i  [2];
    logic        rdy     [2];
    logic        done    [2];
    logic        ract    [2];
    logic        cke0    [2];
    logic        cke1    [2];
    logic        cs0     [2];
    logic        ras0    [2];
    logic        cas0    [2];
    logic        we0     [2];
    logic [1:0]  ba0     [2];
    logic [12:0] ad0     [2];
    logic        cs1     [2];
    logic        ras1    [2];
    logic        cas1    [2];
    logic        we1     [2];
    logic [1:0]  ba1     [2];
    logic [12:0] ad1     [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ddr_cmd_sequencer #(
            .NUM_AD(13), .NUM_BA(2), .T_INIT(TI), .T_RP(TRP), .T_MRD(TMRD),
            .T_RFC(TRFC), .T_REFI((g == 0) ? TREFI_A : TREFI_B),
            .MR_VALUE(MRV), .EMR_VALUE(EMRV)
        ) dut (
            .sys_clk(sys_clk), .sys_rst(sys_rst),
            .cmd_valid(valid[g]), .cmd_ready(rdy[g]),
            .cmd_ras_n(ras_i[g]), .cmd_cas_n(cas_i[g]), .cmd_we_n(we_i[g]),
            .cmd_bank(bank_i[g]), .cmd_address(addr_i[g]),
            .init_done(done[g]), .refresh_active(ract[g]),
            .dfi_cke_p0(cke0[g]), .dfi_cke_p1(cke1[g]),
            .dfi_cs_n_p0(cs0[g]), .dfi_ras_n_p0(ras0[g]), .dfi_cas_n_p0(cas0[g]),
            .dfi_we_n_p0(we0[g]), .dfi_bank_p0(ba0[g]), .dfi_address_p0(ad0[g]),
            .dfi_cs_n_p1(cs1[g]), .dfi_ras_n_p1(ras1[g]), .dfi_cas_n_p1(cas1[g]),
            .dfi_we_n_p1(we1[g]), .dfi_bank_p1(ba1[g]), .dfi_address_p1(ad1[g])
        );
    end

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Reference model state.
    int          init_t [7];
    logic [3:0]  init_c [7];
    logic [1:0]  init_b [7];
    logic [12:0] init_a [7];
    int          init_end;
    bit          pend   [2];
    int          ref_e  [2];
    bit          m_rdy  [2];
    bit          xfer   [2];
    logic [3:0]  xcmd   [2];
    logic [1:0]  xba    [2];
    logic [12:0] xad    [2];
    int          cyc;
    bit          in_rst;
    bit          second;
    int          n_checks;
    int          n_pass;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @cycle %0d: got 0x%0h, want 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    // Power-up command list: each entry is issued the spacing of the previous
    // command after it; init_done follows T_MRD after the last LMR.
    task automatic build_init_table();
        int t;
        int gap [7];
        init_c = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0001, 4'b0001, 4'b0000};
        init_b = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        init_a = '{13'h0400, EMRV, MRV | 13'h0100, 13'h0400, 13'h0000, 13'h0000, MRV & ~13'h0100};
        gap    = '{TRP, TMRD, TMRD, TRP, TRFC, TRFC, TMRD};
        t = TI + 1;
        for (int i = 0; i < 7; i++) begin
            init_t[i] = t;
            t = t + gap[i];
        end
        init_end = t;
    endtask

    task automatic model_and_check(input int k, input int trefi);
        logic [3:0]  ec;
        logic [1:0]  eb;
        logic [12:0] ea;
        logic [3:0]  ep1;
        bit          ecke;
        bit          edone;
        if (in_rst) begin
            ec = 4'hF; eb = 2'd0; ea = 13'd0; ep1 = 4'hF; ecke = 1'b0; edone = 1'b0;
            pend[k] = 1'b0; m_rdy[k] = 1'b0; xfer[k] = 1'b0;
        end else begin
            ec = 4'b0111; eb = 2'd0; ea = 13'd0; ep1 = 4'b0111;
            ecke  = (cyc >= TI);
            edone = (cyc >= init_end);
            for (int i = 0; i < 7; i++) begin
                if (cyc == init_t[i]) begin
                    ec = init_c[i]; eb = init_b[i]; ea = init_a[i];
                end
            end
            if (xfer[k]) begin
                ec = xcmd[k]; eb = xba[k]; ea = xad[k];
            end
            if (pend[k]) begin
                if (cyc == ref_e[k] + TRP) begin
                    ec = 4'b0010; ea = 13'h0400;
                end else if (cyc == ref_e[k] + 2 * TRP) begin
                    ec = 4'b0001;
                end else if (cyc == ref_e[k] + 2 * TRP + TRFC) begin
                    pend[k] = 1'b0;
                end
            end
            if (cyc > init_end && ((cyc - init_end) % trefi) == 0 && !pend[k]) begin
                pend[k]  = 1'b1;
                ref_e[k] = cyc;
            end
            m_rdy[k] = edone && !pend[k];
        end
        check_eq($sformatf("p0_cmd[%0d]", k), {cs0[k], ras0[k], cas0[k], we0[k]}, ec);
        check_eq($sformatf("p0_bank[%0d]", k), ba0[k], eb);
        check_eq($sformatf("p0_addr[%0d]", k), ad0[k], ea);
        check_eq($sformatf("cke[%0d]", k), {cke0[k], cke1[k]}, {ecke, ecke});
        check_eq($sformatf("p1[%0d]", k), {cs1[k], ras1[k], cas1[k], we1[k], ba1[k], ad1[k]}, {ep1, 2'd0, 13'd0});
        check_eq($sformatf("init_done[%0d]", k), done[k], edone);
        check_eq($sformatf("cmd_ready[%0d]", k), rdy[k], m_rdy[k]);
        check_eq($sformatf("refresh_active[%0d]", k), ract[k], pend[k]);
    endtask

    task automatic drive_inputs();
        if (!second || cyc < 28 || cyc > 95) begin
            valid[0] = 1'($urandom_range(0, 1));
            {ras_i[0], cas_i[0], we_i[0]} = 3'($urandom);
            bank_i[0] = 2'($urandom);
            addr_i[0] = 13'($urandom);
        end else if (cyc < 30) begin
            valid[0] = 1'b0;
        end else begin
            valid[0] = 1'b1;
            {ras_i[0], cas_i[0], we_i[0]} = 3'b011;
            bank_i[0] = 2'd2;
            addr_i[0] = 13'h0123;
        end
        for (int k = 0; k < 2; k++) begin
            xfer[k] = valid[k] && m_rdy[k];
            xcmd[k] = {1'b0, ras_i[k], cas_i[k], we_i[k]};
            xba[k]  = bank_i[k];
            xad[k]  = addr_i[k];
        end
    endtask

    task automatic step_and_check();
        @(posedge sys_clk);
        #1;
        if (!in_rst) cyc++;
        model_and_check(0, TREFI_A);
        model_and_check(1, TREFI_B);
        drive_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        second   = 1'b0;
        in_rst   = 1'b1;
        sys_rst  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            valid[k] = 1'b0; ras_i[k] = 1'b1; cas_i[k] = 1'b1; we_i[k] = 1'b1;
            bank_i[k] = 2'd0; addr_i[k] = 13'd0; ref_e[k] = 0;
        end
        build_init_table();
        repeat (2) step_and_check();

        // First power-up, interrupted by reset at cycle 18.
        sys_rst = 1'b0;
        in_rst  = 1'b0;
        cyc     = 0;
        repeat (18) step_and_check();
        sys_rst = 1'b1;
        in_rst  = 1'b1;
        #1;
        model_and_check(0, TREFI_A);
        model_and_check(1, TREFI_B);
        repeat (2) step_and_check();

        // Full rerun: power-up, held host ACT stream across the first
        // refresh, then random host traffic.
        sys_rst = 1'b0;
        in_rst  = 1'b0;
        second  = 1'b1;
        cyc     = 0;
        drive_inputs();
        repeat (400) step_and_check();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
